xy_input_unit: RTL and testbench
================================

# xy_input_unit

Per-input-port front end of the mesh router switch. It buffers incoming flits in a small FIFO and computes the XY route of each packet from its header flit. It then drives a one-hot request toward the per-output-channel allocators and pops flits into the crossbar once the granted output is ready. It sits directly upstream of the allocators: its `req_o`, `data_vld_o` and `flit_id_is_tail_o` feed the allocators' request, valid and tail inputs.

## Interface
Parameters:
- `DATA_W`, 8: flit payload width.
- `FLIT_ID_W`, 2: flit ID width. Flit = {id, payload}; `FLIT_W = FLIT_ID_W + DATA_W`.
- `ROW_ADDR_W`, 2: destination row field width.
- `COL_ADDR_W`, 2: destination column field width.
- `ROW_CORD`, 0: this router's row.
- `COL_CORD`, 0: this router's column.
- `FIFO_DEPTH_W`, 2: FIFO depth is `2**FIFO_DEPTH_W`.
- `OUT_N`, 5: number of output channels. Index 0 local, 1 north, 2 east, 3 south, 4 west.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `data_i` in `FLIT_W`: incoming flit.
- `wr_en_i` in 1: write strobe from the upstream link.
- `rdy_o` out 1: FIFO not full.
- `req_o` out `OUT_N`: one-hot output request.
- `grant_i` in `OUT_N`: held grants from the allocators.
- `oc_rdy_i` in `OUT_N`: per-output forward-node ready.
- `data_o` out `FLIT_W`: FIFO head flit.
- `data_vld_o` out 1: FIFO non-empty.
- `flit_id_is_tail_o` out 1: head flit ID equals TAIL.
- `err_o` out 1: one-cycle pulse when an orphan flit is dropped.

## Operation
- Flit IDs: HEAD=2'b10, BODY=2'b01, TAIL=2'b11, 2'b00 reserved/illegal.
- Header payload layout: dst col = `data[COL_ADDR_W-1:0]`; dst row = `data[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W]`.
- XY routing, column first:
  - dst col > `COL_CORD` → east; dst col < `COL_CORD` → west.
  - Columns equal: dst row > `ROW_CORD` → south (rows grow southward); dst row < `ROW_CORD` → north.
  - Both equal → local. Comparisons are unsigned.
- FSM states:
  - IDLE: `req_o`=0. If the FIFO head is a HEAD flit, register `route_q` = xy(head) and go to ROUTED; the head is not popped. If the head is BODY, TAIL or 00, pop it, pulse `err_o`, stay in IDLE.
  - ROUTED: `req_o` = `route_q`. Pop when `data_vld_o & |(grant_i & route_q & oc_rdy_i)`. Popping a TAIL returns to IDLE and clears `route_q`.
- Grant bits outside `route_q` are ignored.
- If the FIFO empties mid-packet in ROUTED, stay in ROUTED with `req_o` held and `data_vld_o`=0.
- FIFO:
  - Push when `wr_en_i & rdy_o`; a write while full is discarded and the FIFO state is unchanged.
  - Simultaneous push and pop keeps the count unchanged.
  - Read and write pointers wrap modulo depth.
  - Occupancy counter is `FIFO_DEPTH_W+1` bits wide.

## Timing
- Reset values: `rdy_o`=1, `req_o`=0, `data_vld_o`=0, `data_o`=0, `flit_id_is_tail_o`=0, `err_o`=0, FSM=IDLE, FIFO empty. Reset asserted mid-packet discards all contents and state.
- Write to visible: a flit written in cycle N appears on `data_o` with `data_vld_o`=1 in N+1 (registered count, no fall-through).
- Route latency: a HEAD at the FIFO front in cycle N gives `req_o` valid from N+1.
- Pop takes effect at the clock edge. The next flit is visible the following cycle, giving one flit per cycle sustained.
- `rdy_o` derives from registered state only, so a pop does not free space in the same cycle.
- `flit_id_is_tail_o` and `data_vld_o` are combinational from the FIFO head. `req_o` and `err_o` are registered or FSM-decoded; there is no combinational path from `grant_i` to `req_o`.

## Structure
- Shared package `noc_pkg`: flit ID localparams HEAD, BODY, TAIL; output port index constants LOCAL, NORTH, EAST, SOUTH, WEST.
- One sub-module: `flit_fifo` (parameters `FLIT_W`, `FIFO_DEPTH_W`; ports push, pop, full, empty, head data).
- Route compute and FSM stay in `xy_input_unit`.

## Test plan
- Node (1,1): write HEAD with dst (row 1, col 3), then BODY, then TAIL; grant east with ready. Expect `req_o`=5'b00100 one cycle after the head is visible, three pops in consecutive cycles, `flit_id_is_tail_o`=1 on the third, then IDLE with `req_o`=0.
- Destinations (1,1), (0,1), (2,1), (1,0) → `req_o` = 00001, 00010, 01000, 10000 respectively.
- Fill 4 flits with no grant: `rdy_o`=0; a 5th write is dropped; granting then yields exactly the 4 original flits in order.
- Grant held with east `oc_rdy_i`=0 for 3 cycles: no pop, `data_o` stable; `oc_rdy_i` → 1 resumes pops.
- BODY flit at the front while in IDLE: popped, `err_o` pulses 1 cycle; a following HEAD routes normally.
- `rst_i` asserted mid-packet in ROUTED with 2 flits buffered: next cycle `req_o`=0, `data_vld_o`=0, `rdy_o`=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit IDs, output-port indices, input-unit FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package noc_pkg;

    // Flit ID field encodings; 2'b00 is reserved and treated as an orphan.
    localparam logic [1:0] HEAD = 2'b10;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b11;

    // Output channel indices into the one-hot request vector.
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ROUTED = 1'b1
    } iu_state_t;

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer: 2**FIFO_DEPTH_W entries, registered occupancy, no fall-through.
// Latency: a push is visible at the head one cycle later; pop acts at the clock edge.
// Backpressure: full/empty come from registered state only; pushes while full are discarded.
//
// Ports: clk/rst (sync active-high), push + push_data, pop, full, empty,
//        head_data (oldest entry, forced to zero while empty).
module flit_fifo #(
    parameter int FLIT_W       = 10,
    parameter int FIFO_DEPTH_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [FLIT_W-1:0] head_data
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_W;
    localparam logic [FIFO_DEPTH_W:0] DEPTH_CNT = (FIFO_DEPTH_W + 1)'(DEPTH);

    logic [FLIT_W-1:0]       mem [DEPTH];
    logic [FIFO_DEPTH_W-1:0] wr_ptr;
    logic [FIFO_DEPTH_W-1:0] rd_ptr;
    logic [FIFO_DEPTH_W:0]   count;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Gate the head so the output is a clean zero after reset / when drained.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: it is only observed through the empty gate.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly FIFO_DEPTH_W bits, so increment wraps modulo depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xy_input_unit.sv
// Router input port: buffers flits, XY-routes each packet from its header, requests one output.
// Latency: write->head visible 1 cycle; head visible->req_o 1 cycle; 1 flit/cycle sustained.
// Backpressure: rdy_o = FIFO not full (registered); pops only on held grant & output ready.
//
// Ports: clk_i/rst_i (sync active-high); data_i/wr_en_i/rdy_o upstream link;
//        req_o/grant_i/oc_rdy_i allocator + crossbar handshake; data_o/data_vld_o/
//        flit_id_is_tail_o head flit view; err_o one-cycle orphan-drop pulse.
module xy_input_unit
    import noc_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FLIT_ID_W    = 2,
    parameter int ROW_ADDR_W   = 2,
    parameter int COL_ADDR_W   = 2,
    parameter int ROW_CORD     = 0,
    parameter int COL_CORD     = 0,
    parameter int FIFO_DEPTH_W = 2,
    parameter int OUT_N        = 5,
    parameter int FLIT_W       = FLIT_ID_W + DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              wr_en_i,
    output logic              rdy_o,
    output logic [OUT_N-1:0]  req_o,
    input  logic [OUT_N-1:0]  grant_i,
    input  logic [OUT_N-1:0]  oc_rdy_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              data_vld_o,
    output logic              flit_id_is_tail_o,
    output logic              err_o
);
    localparam int ADDR_W = ROW_ADDR_W + COL_ADDR_W;
    localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
    localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);
    localparam logic [FLIT_ID_W-1:0]  ID_HEAD = FLIT_ID_W'(HEAD);
    localparam logic [FLIT_ID_W-1:0]  ID_TAIL = FLIT_ID_W'(TAIL);

    // Column first, then row; rows grow southward. Unsigned compares.
    function automatic logic [OUT_N-1:0] xy_route(input logic [ADDR_W-1:0] addr);
        logic [COL_ADDR_W-1:0] dst_col;
        logic [ROW_ADDR_W-1:0] dst_row;
        logic [OUT_N-1:0]      r;
        dst_col = addr[COL_ADDR_W-1:0];
        dst_row = addr[ADDR_W-1:COL_ADDR_W];
        r = '0;
        if (dst_col > MY_COL) begin
            r[EAST] = 1'b1;
        end else if (dst_col < MY_COL) begin
            r[WEST] = 1'b1;
        end else if (dst_row > MY_ROW) begin
            r[SOUTH] = 1'b1;
        end else if (dst_row < MY_ROW) begin
            r[NORTH] = 1'b1;
        end else begin
            r[LOCAL] = 1'b1;
        end
        return r;
    endfunction

    iu_state_t            state;
    logic [OUT_N-1:0]     route_q;
    logic                 err_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [FLIT_ID_W-1:0] head_id;
    logic                 head_is_head;
    logic                 grant_hit;

    flit_fifo #(
        .FLIT_W       (FLIT_W),
        .FIFO_DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (wr_en_i),
        .push_data (data_i),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (data_o)
    );

    assign rdy_o             = ~fifo_full;
    assign data_vld_o        = ~fifo_empty;
    assign head_id           = data_o[FLIT_W-1:DATA_W];
    assign head_is_head      = (head_id == ID_HEAD);
    assign flit_id_is_tail_o = data_vld_o & (head_id == ID_TAIL);

    // Only grants on our own route count; stray grant bits are masked off.
    assign grant_hit = |(grant_i & route_q & oc_rdy_i);

    // IDLE drops anything that is not a header; ROUTED forwards on a usable grant.
    assign fifo_pop = data_vld_o &
                      (((state == ST_IDLE) & ~head_is_head) |
                       ((state == ST_ROUTED) & grant_hit));

    // route_q is zero whenever IDLE, so it can drive req_o directly.
    assign req_o = route_q;
    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_vld_o) begin
                        if (head_is_head) begin
                            route_q <= xy_route(data_o[ADDR_W-1:0]);
                            state   <= ST_ROUTED;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ROUTED: begin
                    // An empty FIFO mid-packet simply holds the request.
                    if (fifo_pop && flit_id_is_tail_o) begin
                        route_q <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    route_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xy_input_unit.sv
module tb_xy_input_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic       rdy;
    logic [4:0] req;
    logic [4:0] grant = '0;
    logic [4:0] oc_rdy = '0;
    logic [9:0] data_out;
    logic       data_vld;
    logic       tail;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered flits plus current packet route.
    logic [9:0] mq[$];
    logic [4:0] m_route = '0;
    bit         m_routed = 1'b0;
    bit         m_err = 1'b0;
    logic [9:0] stim[$];

    xy_input_unit #(
        .DATA_W       (8),
        .FLIT_ID_W    (2),
        .ROW_ADDR_W   (2),
        .COL_ADDR_W   (2),
        .ROW_CORD     (1),
        .COL_CORD     (1),
        .FIFO_DEPTH_W (2),
        .OUT_N        (5)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .data_i            (data_in),
        .wr_en_i           (wr_en),
        .rdy_o             (rdy),
        .req_o             (req),
        .grant_i           (grant),
        .oc_rdy_i          (oc_rdy),
        .data_o            (data_out),
        .data_vld_o        (data_vld),
        .flit_id_is_tail_o (tail),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    // Router sits at (row 1, col 1).
    function automatic logic [4:0] exp_route(int r, int c);
        if (c > 1) return 5'b00100;
        if (c < 1) return 5'b10000;
        if (r > 1) return 5'b01000;
        if (r < 1) return 5'b00010;
        return 5'b00001;
    endfunction

    function automatic logic [9:0] mk_head(int r, int c);
        return {2'b10, 4'b0000, 2'(r), 2'(c)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare all outputs.
    task automatic cycle(input bit r, input bit w, input logic [9:0] d,
                         input logic [4:0] g, input logic [4:0] o, output bit acc);
        bit         pop;
        bit         was_full;
        logic [9:0] h;
        rst = r; wr_en = w; data_in = d; grant = g; oc_rdy = o;
        @(posedge clk);
        #1;
        acc = 1'b0;
        if (r) begin
            mq.delete();
            m_routed = 1'b0;
            m_route  = '0;
            m_err    = 1'b0;
        end else begin
            pop      = 1'b0;
            was_full = (mq.size() == 4);
            m_err    = 1'b0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (!m_routed) begin
                    if (h[9:8] == 2'b10) begin
                        m_routed = 1'b1;
                        m_route  = exp_route(int'(h[3:2]), int'(h[1:0]));
                    end else begin
                        pop   = 1'b1;
                        m_err = 1'b1;
                    end
                end else if ((g & m_route & o) != 5'b0) begin
                    pop = 1'b1;
                    if (h[9:8] == 2'b11) begin
                        m_routed = 1'b0;
                        m_route  = '0;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (w && !was_full) begin
                mq.push_back(d);
                acc = 1'b1;
            end
        end
        h = (mq.size() > 0) ? mq[0] : 10'h0;
        chk("rdy",  16'(rdy),      16'(mq.size() < 4));
        chk("vld",  16'(data_vld), 16'(mq.size() > 0));
        chk("data", 16'(data_out), 16'(h));
        chk("tail", 16'(tail),     16'((mq.size() > 0) && (h[9:8] == 2'b11)));
        chk("req",  16'(req),      16'(m_route));
        chk("err",  16'(err),      16'(m_err));
    endtask

    task automatic gen_pkt();
        int kind;
        int nb;
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
            case ($urandom_range(0, 2))
                0:       stim.push_back({2'b00, 8'($urandom)});
                1:       stim.push_back({2'b01, 8'($urandom)});
                default: stim.push_back({2'b11, 8'($urandom)});
            endcase
        end else begin
            stim.push_back({2'b10, 4'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
            nb = $urandom_range(0, 2);
            for (int i = 0; i < nb; i++) stim.push_back({2'b01, 8'($urandom)});
            stim.push_back({2'b11, 8'($urandom)});
        end
    endtask

    initial begin
        bit         a;
        logic [9:0] fill [4];
        logic [4:0] dst_exp [4];
        int         dst_r [4];
        int         dst_c [4];
        logic [4:0] g;
        logic [4:0] o;
        bit         w;
        bit         r;

        // Reset state
        cycle(1, 0, '0, '0, '0, a);
        cycle(1, 0, '0, '0, '0, a);
        chk("reset_rdy", 16'(rdy), 16'd1);
        chk("reset_req", 16'(req), 16'd0);
        chk("reset_vld", 16'(data_vld), 16'd0);

        // HEAD to (1,3) -> east, then BODY, TAIL
        cycle(0, 1, mk_head(1, 3), '0, '0, a);
        chk("hdr_visible", 16'(data_out), 16'(mk_head(1, 3)));
        cycle(0, 1, {2'b01, 8'hA5}, 5'b00100, 5'b11111, a);
        chk("east_req", 16'(req), 16'b00100);
        cycle(0, 1, {2'b11, 8'h3C}, 5'b00100, 5'b11111, a);
        cycle(0, 0, '0, 5'b00100, 5'b11111, a);
        chk("tail_flag", 16'(tail), 16'd1);
        cycle(0, 0, '0, 5'b00100, 5'b11111, a);
        chk("idle_req", 16'(req), 16'd0);

        // Each destination; wrong grant bits first must not pop
        dst_r[0] = 1; dst_c[0] = 1; dst_exp[0] = 5'b00001;
        dst_r[1] = 0; dst_c[1] = 1; dst_exp[1] = 5'b00010;
        dst_r[2] = 2; dst_c[2] = 1; dst_exp[2] = 5'b01000;
        dst_r[3] = 1; dst_c[3] = 0; dst_exp[3] = 5'b10000;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, mk_head(dst_r[i], dst_c[i]), '0, '0, a);
            cycle(0, 1, {2'b11, 8'h55}, '0, '0, a);
            chk("dst_req", 16'(req), 16'(dst_exp[i]));
            cycle(0, 0, '0, ~dst_exp[i], 5'b11111, a);
            chk("stray_grant", 16'(data_out), 16'(mk_head(dst_r[i], dst_c[i])));
            cycle(0, 0, '0, dst_exp[i], 5'b11111, a);
            cycle(0, 0, '0, dst_exp[i], 5'b11111, a);
        end

        // Fill to full with no grant; fifth write dropped; drain in order
        fill[0] = mk_head(1, 2);
        fill[1] = {2'b01, 8'h11};
        fill[2] = {2'b01, 8'h22};
        fill[3] = {2'b11, 8'h33};
        for (int i = 0; i < 4; i++) cycle(0, 1, fill[i], '0, '0, a);
        chk("full_rdy", 16'(rdy), 16'd0);
        cycle(0, 1, {2'b01, 8'hFF}, '0, '0, a);
        chk("full_drop", 16'(a), 16'd0);
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", 16'(data_out), 16'(fill[i]));
            cycle(0, 0, '0, 5'b00100, 5'b00100, a);
        end
        chk("fill_empty", 16'(data_vld), 16'd0);

        // Held grant, output not ready for 3 cycles
        cycle(0, 1, mk_head(0, 3), '0, '0, a);
        cycle(0, 1, {2'b01, 8'h77}, 5'b00100, 5'b00000, a);
        cycle(0, 1, {2'b11, 8'h88}, 5'b00100, 5'b00000, a);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, 5'b00100, 5'b11011, a);
            chk("stall_data", 16'(data_out), 16'(mk_head(0, 3)));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 5'b00100, 5'b11111, a);
        chk("stall_done", 16'(data_vld), 16'd0);

        // Orphan BODY dropped with err pulse, then a normal packet
        cycle(0, 1, {2'b01, 8'h99}, '0, '0, a);
        cycle(0, 1, mk_head(0, 1), '0, '0, a);
        chk("orphan_err", 16'(err), 16'd1);
        cycle(0, 1, {2'b11, 8'h44}, '0, '0, a);
        chk("orphan_err_end", 16'(err), 16'd0);
        chk("orphan_next_req", 16'(req), 16'b00010);
        cycle(0, 0, '0, 5'b00010, 5'b00010, a);
        cycle(0, 0, '0, 5'b00010, 5'b00010, a);

        // Reset mid-packet with 2 flits buffered
        cycle(0, 1, mk_head(1, 0), '0, '0, a);
        cycle(0, 1, {2'b01, 8'h61}, '0, '0, a);
        cycle(0, 1, {2'b01, 8'h62}, 5'b10000, 5'b10000, a);
        cycle(1, 0, '0, '0, '0, a);
        chk("rst_req", 16'(req), 16'd0);
        chk("rst_vld", 16'(data_vld), 16'd0);
        chk("rst_rdy", 16'(rdy), 16'd1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            if (stim.size() < 6) gen_pkt();
            r = ($urandom_range(0, 249) == 0);
            w = ($urandom_range(0, 3) != 0);
            g = 5'($urandom);
            if ($urandom_range(0, 1) == 1) g = g | m_route;
            o = ($urandom_range(0, 2) != 0) ? 5'b11111 : 5'($urandom);
            cycle(r, w, stim[0], g, o, a);
            if (a) void'(stim.pop_front());
        end

        // Drain
        for (int n = 0; n < 12; n++) cycle(0, 0, '0, 5'b11111, 5'b11111, a);
        chk("drain_vld", 16'(data_vld), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
